// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state, read-select and command bit definitions for the PIC sequencer
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT2 = 3'd1,
        ST_WAIT3 = 3'd2,
        ST_WAIT4 = 3'd3,
        ST_READY = 3'd4
    } pic_state_t;

    localparam logic [1:0] RSEL_IRR  = 2'b00;
    localparam logic [1:0] RSEL_ISR  = 2'b01;
    localparam logic [1:0] RSEL_IMR  = 2'b10;
    localparam logic [1:0] RSEL_POLL = 2'b11;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CMD_D3    = 3;
    localparam int CMD_D4    = 4;
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;

endpackage

// File: rtl/pic_bus_capture.sv
// rtl/pic_bus_capture.sv - write-strobe rising-edge detect plus data/A0 latch
module pic_bus_capture #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_edge,
    output logic              a0_q,
    output logic [DATA_W-1:0] data_latched
);

    logic              r_wr_q;
    logic              r_a0;
    logic [DATA_W-1:0] r_data;

    // Dropping chip select forces the history high, so a write aborted by cs_n never edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_q <= 1'b1;
            r_a0   <= 1'b0;
            r_data <= '0;
        end else begin
            r_wr_q <= cs_n ? 1'b1 : wr_n;
            if (!cs_n && !wr_n) begin
                r_data <= data_in;
                r_a0   <= a0;
            end
        end
    end

    assign wr_edge      = ~r_wr_q & wr_n & ~cs_n;
    assign a0_q         = r_a0;
    assign data_latched = r_data;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// rtl/pic_cmd_sequencer.sv - PIC bus front end: ICW init sequence, OCW decode and read-select tracking
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int   DATA_W      = 8,
    parameter logic RESET_RDSEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_latched,
    output logic              wr_icw1,
    output logic              wr_icw2,
    output logic              wr_icw3,
    output logic              wr_icw4,
    output logic              wr_ocw1,
    output logic              wr_ocw2,
    output logic              wr_ocw3,
    output logic              init_done,
    output logic              sngl,
    output logic              ic4,
    output logic              read_en,
    output logic [1:0]        read_sel,
    output logic              cmd_error
);

    logic              w_wr_edge;
    logic              w_a0_q;
    logic [DATA_W-1:0] w_data;
    logic              w_is_icw1;
    logic [6:0]        w_strb;
    logic              w_err;
    pic_state_t        w_state_nxt;

    pic_state_t        r_state;
    logic [6:0]        r_strb;
    logic              r_err;
    logic              r_sngl;
    logic              r_ic4;
    logic              r_rdsel;
    logic              r_poll;
    logic              r_read_en_q;

    pic_bus_capture #(.DATA_W(DATA_W)) u_capture (
        .clk          (clk),
        .rst          (rst),
        .cs_n         (cs_n),
        .wr_n         (wr_n),
        .a0           (a0),
        .data_in      (data_in),
        .wr_edge      (w_wr_edge),
        .a0_q         (w_a0_q),
        .data_latched (w_data)
    );

    assign w_is_icw1 = ~w_a0_q & w_data[CMD_D4];

    // w_strb bit order: 6=icw1 5=icw2 4=icw3 3=icw4 2=ocw1 1=ocw2 0=ocw3
    always_comb begin
        w_strb      = '0;
        w_err       = 1'b0;
        w_state_nxt = r_state;
        if (w_wr_edge) begin
            if (w_is_icw1) begin
                w_strb[6]   = 1'b1;
                w_state_nxt = ST_WAIT2;
            end else begin
                case (r_state)
                    ST_WAIT2: begin
                        if (w_a0_q) begin
                            w_strb[5]   = 1'b1;
                            w_state_nxt = !r_sngl ? ST_WAIT3 : (r_ic4 ? ST_WAIT4 : ST_READY);
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    ST_WAIT3: begin
                        if (w_a0_q) begin
                            w_strb[4]   = 1'b1;
                            w_state_nxt = r_ic4 ? ST_WAIT4 : ST_READY;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    ST_WAIT4: begin
                        if (w_a0_q) begin
                            w_strb[3]   = 1'b1;
                            w_state_nxt = ST_READY;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (w_a0_q)                w_strb[2] = 1'b1;
                        else if (!w_data[CMD_D3])  w_strb[1] = 1'b1;
                        else                       w_strb[0] = 1'b1;
                    end
                    default: w_err = 1'b1;
                endcase
            end
        end
    end

    assign read_en = ~cs_n & ~rd_n & wr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_strb      <= '0;
            r_err       <= 1'b0;
            r_sngl      <= 1'b0;
            r_ic4       <= 1'b0;
            r_rdsel     <= RESET_RDSEL;
            r_poll      <= 1'b0;
            r_read_en_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_strb      <= w_strb;
            r_err       <= w_err;
            r_read_en_q <= read_en;
            if (w_strb[6]) begin
                r_sngl  <= w_data[ICW1_SNGL];
                r_ic4   <= w_data[ICW1_IC4];
                r_rdsel <= RESET_RDSEL;
                r_poll  <= 1'b0;
            end else begin
                if (w_strb[0] && w_data[OCW3_RR]) r_rdsel <= w_data[OCW3_RIS];
                // A poll request wins over a read completing in the same cycle.
                if (w_strb[0] && w_data[OCW3_P])      r_poll <= 1'b1;
                else if (r_read_en_q && !read_en)     r_poll <= 1'b0;
            end
        end
    end

    assign data_latched = w_data;
    assign {wr_icw1, wr_icw2, wr_icw3, wr_icw4, wr_ocw1, wr_ocw2, wr_ocw3} = r_strb;
    assign cmd_error    = r_err;
    assign init_done    = (r_state == ST_READY);
    assign sngl         = r_sngl;
    assign ic4          = r_ic4;
    assign read_sel     = a0 ? RSEL_IMR : (r_poll ? RSEL_POLL : {1'b0, r_rdsel});

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// tb/tb_pic_cmd_sequencer.sv - directed self-checking bench for pic_cmd_sequencer
module tb_pic_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_latched;
    logic       wr_icw1, wr_icw2, wr_icw3, wr_icw4;
    logic       wr_ocw1, wr_ocw2, wr_ocw3;
    logic       init_done, sngl, ic4, read_en, cmd_error;
    logic [1:0] read_sel;

    int n_vec = 0;
    int n_err = 0;

    pic_cmd_sequencer #(.DATA_W(8), .RESET_RDSEL(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .cs_n         (cs_n),
        .rd_n         (rd_n),
        .wr_n         (wr_n),
        .a0           (a0),
        .data_in      (data_in),
        .data_latched (data_latched),
        .wr_icw1      (wr_icw1),
        .wr_icw2      (wr_icw2),
        .wr_icw3      (wr_icw3),
        .wr_icw4      (wr_icw4),
        .wr_ocw1      (wr_ocw1),
        .wr_ocw2      (wr_ocw2),
        .wr_ocw3      (wr_ocw3),
        .init_done    (init_done),
        .sngl         (sngl),
        .ic4          (ic4),
        .read_en      (read_en),
        .read_sel     (read_sel),
        .cmd_error    (cmd_error)
    );

    always #5 clk = ~clk;

    // strobe vector: icw1 icw2 icw3 icw4 ocw1 ocw2 ocw3 cmd_error
    function automatic logic [7:0] strobes();
        return {wr_icw1, wr_icw2, wr_icw3, wr_icw4, wr_ocw1, wr_ocw2, wr_ocw3, cmd_error};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full bus write; returns the strobe vector sampled in the cycle after the detecting edge.
    task automatic bus_write(input logic addr, input logic [7:0] d, output logic [7:0] strb);
        @(negedge clk);
        cs_n = 1'b0; a0 = addr; data_in = d; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        @(posedge clk);
        #1 strb = strobes();
        @(negedge clk);
        cs_n = 1'b1; a0 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] s;

    initial begin
        do_reset();
        chk("rst_strobes", strobes(), 8'h00);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_sngl_ic4", {sngl, ic4}, 2'b00);
        chk("rst_data", data_latched, 8'h00);
        chk("rst_read_sel", read_sel, 2'b00);

        // ICW1 single, IC4 -> ICW2 -> ICW4
        bus_write(1'b0, 8'h13, s);
        chk("t1_icw1", s, 8'h80);
        chk("t1_sngl_ic4", {sngl, ic4}, 2'b11);
        chk("t1_not_done", init_done, 1'b0);
        bus_write(1'b1, 8'h20, s);
        chk("t1_icw2", s, 8'h40);
        chk("t1_not_done2", init_done, 1'b0);
        bus_write(1'b1, 8'h01, s);
        chk("t1_icw4", s, 8'h10);
        chk("t1_done", init_done, 1'b1);

        // ICW1 cascade, no IC4 -> ICW2 -> ICW3 -> READY
        bus_write(1'b0, 8'h10, s);
        chk("t2_icw1", s, 8'h80);
        chk("t2_sngl_ic4", {sngl, ic4}, 2'b00);
        chk("t2_not_done", init_done, 1'b0);
        bus_write(1'b1, 8'h20, s);
        chk("t2_icw2", s, 8'h40);
        bus_write(1'b0, 8'h00, s);
        chk("t2_bad_in_wait3", s, 8'h01);
        bus_write(1'b1, 8'h00, s);
        chk("t2_icw3", s, 8'h20);
        chk("t2_done", init_done, 1'b1);

        // Illegal write in IDLE
        do_reset();
        bus_write(1'b1, 8'hFF, s);
        chk("t3_err", s, 8'h01);
        chk("t3_idle", init_done, 1'b0);
        @(posedge clk); #1;
        chk("t3_err_one_cycle", strobes(), 8'h00);
        bus_write(1'b1, 8'h20, s);
        chk("t3_still_idle", s, 8'h01);

        // Reach READY (single, no IC4), OCW3 read-select and poll
        bus_write(1'b0, 8'h12, s);
        chk("t4_icw1", s, 8'h80);
        bus_write(1'b1, 8'h20, s);
        chk("t4_icw2", s, 8'h40);
        chk("t4_done", init_done, 1'b1);
        bus_write(1'b0, 8'h0B, s);
        chk("t4_ocw3", s, 8'h02);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b0;
        #1;
        chk("t4_read_en", read_en, 1'b1);
        chk("t4_sel_isr", read_sel, 2'b01);
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
        bus_write(1'b0, 8'h0C, s);
        chk("t4_ocw3_poll", s, 8'h02);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b0;
        #1;
        chk("t4_sel_poll", read_sel, 2'b11);
        @(negedge clk);
        rd_n = 1'b1;
        #1;
        chk("t4_sel_poll_hold", read_sel, 2'b11);
        @(posedge clk); #1;
        chk("t4_sel_after_poll", read_sel, 2'b01);
        @(negedge clk);
        cs_n = 1'b1;

        // OCW2 / OCW1 and IMR select
        bus_write(1'b0, 8'h20, s);
        chk("t5_ocw2", s, 8'h04);
        bus_write(1'b1, 8'hAA, s);
        chk("t5_ocw1", s, 8'h08);
        chk("t5_data", data_latched, 8'hAA);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b1;
        #1;
        chk("t5_sel_imr", read_sel, 2'b10);
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1; a0 = 1'b0;

        // Asynchronous reset during WAIT3
        bus_write(1'b0, 8'h11, s);
        chk("t6_icw1", s, 8'h80);
        chk("t6_ic4", ic4, 1'b1);
        bus_write(1'b1, 8'h20, s);
        chk("t6_icw2", s, 8'h40);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_ic4", ic4, 1'b0);
        chk("t6_async_data", data_latched, 8'h00);
        chk("t6_async_strobes", strobes(), 8'h00);
        chk("t6_async_done", init_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus_write(1'b1, 8'h00, s);
        chk("t6_idle_after_rst", s, 8'h01);

        // cs_n raised before wr_n rises: write lost
        @(negedge clk);
        cs_n = 1'b0; a0 = 1'b0; data_in = 8'h13; wr_n = 1'b0;
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        wr_n = 1'b1;
        @(posedge clk); #1;
        chk("t7_abort_strobes", strobes(), 8'h00);
        @(posedge clk); #1;
        chk("t7_abort_strobes2", strobes(), 8'h00);
        chk("t7_abort_sngl", sngl, 1'b0);

        // Read and write together
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_in = 8'h55;
        #1;
        chk("t8_rdwr_read_en", read_en, 1'b0);
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        rd_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); #1;
        chk("t8_no_strobe", strobes(), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pic_cmd_sequencer.md
Name: pic_cmd_sequencer

Overview:
- Parametrised successor to the PIC's bus read/write front end.
- Detects the rising edge of the processor write on the bus and latches data and A0. It then runs the full ICW1→ICW2→(ICW3)→(ICW4) initialisation sequence as a state machine, honouring the SNGL and IC4 bits.
- Decodes OCW1–3 only after initialisation, tracks the OCW3 read-register and poll selection, and flags illegal writes.
- Sits between the external bus pins and the PIC control logic, interrupt-mask register (IMR) and priority resolver.

Parameters:
- DATA_W, 8, width of the data bus. Must be ≥8. Command decode uses bits [4:0]; all bits pass through on data_latched.
- RESET_RDSEL, 0, read-register select after reset and after ICW1 (0=IRR, 1=ISR).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cs_n  in  1  chip select, active low
- rd_n  in  1  read strobe, active low
- wr_n  in  1  write strobe, active low
- a0  in  1  address bit 0
- data_in  in  DATA_W  processor data bus
- data_latched  out  DATA_W  data captured during the last write
- wr_icw1, wr_icw2, wr_icw3, wr_icw4  out  1 each  one-cycle ICW strobes
- wr_ocw1, wr_ocw2, wr_ocw3  out  1 each  one-cycle OCW strobes
- init_done  out  1  high in READY
- sngl, ic4  out  1 each  captured from ICW1 D1 and D0
- read_en  out  1  processor read in progress
- read_sel  out  2  00=IRR, 01=ISR, 10=IMR, 11=POLL
- cmd_error  out  1  one-cycle pulse on an illegal write

Behaviour:
- Reset (rst=1, async) sets:
  - all strobes, cmd_error, init_done, sngl, ic4 = 0
  - data_latched = 0, latched A0 = 0
  - wr_q = 1, state = IDLE
  - rdsel_q = RESET_RDSEL, poll_pending = 0
- Capture: each clk edge where cs_n=0 and wr_n=0 loads data_latched←data_in and a0_q←a0.
- Write-edge tracking:
  - wr_q←wr_n, except wr_q←1 whenever cs_n=1.
  - An edge is detected at a clk edge where wr_q=0, wr_n=1 and cs_n=0.
- Strobe timing: all strobes are registered. They are high exactly one cycle, the cycle after the detecting edge, and decode a0_q/data_latched as they stood before the detecting edge.
- ICW1 condition: a0_q=0 and D4=1.
  - Accepted in any state: wr_icw1, sngl←D1, ic4←D0, poll_pending←0, rdsel_q←RESET_RDSEL, state←WAIT2.
- WAIT2, write with a0_q=1: wr_icw2; next state is WAIT3 if !sngl, else WAIT4 if ic4, else READY.
- WAIT3, write with a0_q=1: wr_icw3; next state is WAIT4 if ic4, else READY.
- WAIT4, write with a0_q=1: wr_icw4; state←READY.
- READY decode:
  - a0_q=1 → wr_ocw1.
  - a0_q=0, D4=0, D3=0 → wr_ocw2.
  - a0_q=0, D4=0, D3=1 → wr_ocw3:
    - if D1=1, rdsel_q←D0;
    - if D2=1, poll_pending←1.
- Illegal writes pulse cmd_error, issue no strobe, and leave the state unchanged. They are:
  - any non-ICW1 write in IDLE;
  - any write with a0_q=0 that is not ICW1 in WAIT2/WAIT3/WAIT4.
- Read path (combinational):
  - read_en = ~cs_n & ~rd_n & wr_n. A simultaneous read and write suppresses read_en.
  - read_sel = 10 if a0=1; else 11 if poll_pending; else {0, rdsel_q}.
- Poll clear: poll_pending clears on the clk edge where read_en falls (registered read_en_q=1, read_en=0). An ICW1 strobe in the same cycle also clears it.
- init_done = (state==READY).
- Bus-level reset: deasserting cs_n mid-write (before wr_n rises) loses the write; no strobe is issued.
- rst mid-sequence returns to IDLE; the processor must reissue ICW1.

Decomposition:
- Shared package pic_pkg holds:
  - state enum: IDLE, WAIT2, WAIT3, WAIT4, READY;
  - read_sel codes: RSEL_IRR, RSEL_ISR, RSEL_IMR, RSEL_POLL;
  - bit-index constants: ICW1_IC4=0, ICW1_SNGL=1, CMD_D3=3, CMD_D4=4, OCW3_RIS=0, OCW3_RR=1, OCW3_P=2.
- One sub-module, pic_bus_capture: edge detect plus data/A0 latch. It outputs wr_edge, a0_q and data_latched.

Test Plan:
- Sequence ICW1=0x13 (SNGL=1, IC4=1), then ICW2=0x20, then ICW4=0x01 → wr_icw1, wr_icw2, wr_icw4 pulses; no wr_icw3; init_done=1 after the 3rd strobe.
- ICW1=0x10, then ICW2, then ICW3 → wr_icw3 fires; READY reached without an ICW4 strobe; sngl=0, ic4=0.
- From IDLE, a write with a0=1 of 0xFF → cmd_error one cycle; no strobe; state stays IDLE.
- In READY, write a0=0 data 0x0B → wr_ocw3; a read with a0=0 gives read_sel=01. Then write 0x0C → read_sel=11 until the rd_n rise, then 01.
- In READY, write a0=0 0x20 → wr_ocw2. Write a0=1 0xAA → wr_ocw1, data_latched=0xAA. A read with a0=1 gives read_sel=10.
- Assert rst during WAIT3 → all outputs zero and state IDLE immediately, without waiting for a clk edge. Also check: cs_n raised before wr_n rises → no strobe; rd_n and wr_n low together → read_en=0.
